// File: rtl/mac8_pkg.sv
// Shared definitions for the MAC8 datapath neighbours: widths, FSM encoding and
// the constant quotient reported for a zero divisor.
package mac8_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int COUNT_W    = 3;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 8'hFF;
    localparam logic [COUNT_W-1:0]    LAST_ITER     = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Start/done handshake and operand/result bus of the sequential 8-by-4 divider.
interface seq_divider_8by4_if;
    import mac8_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_8by4_sub_stage.sv
// One restoring-division step: 5-bit trial compare/subtract of T against the divisor.
module div_sub_stage
    import mac8_pkg::*;
(
    input  logic [DIVISOR_W:0]   t,
    input  logic [DIVISOR_W-1:0] d,
    output logic [DIVISOR_W-1:0] r_next,
    output logic                 q_bit
);

    logic [DIVISOR_W-1:0] diff_s;

    // The new remainder is always below D, so its low four bits carry all of it.
    always_comb begin
        q_bit  = (t >= {1'b0, d});
        diff_s = t[DIVISOR_W-1:0] - d;
        if (q_bit) begin
            r_next = diff_s;
        end else begin
            r_next = t[DIVISOR_W-1:0];
        end
    end

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit
// per clock, with start/done control and registered results.
module seq_divider_8by4
    import mac8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    seq_divider_8by4_if.slave bus
);

    div_state_e            state_r;
    div_state_e            state_n;
    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVISOR_W-1:0]  d_r;
    logic [DIVISOR_W-1:0]  r_r;
    logic [COUNT_W-1:0]    cnt_r;
    logic                  pend_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  dbz_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;

    logic                  accept_s;
    logic                  run_finish_s;
    logic                  dz_finish_s;
    logic                  div_zero_s;
    logic [DIVISOR_W:0]    trial_s;
    logic [DIVISOR_W-1:0]  r_next_s;
    logic                  q_bit_s;

    assign div_zero_s = (bus.divisor == {DIVISOR_W{1'b0}});
    assign trial_s    = {r_r, q_r[DIVIDEND_W-1]};

    div_sub_stage u_sub (
        .t      (trial_s),
        .d      (d_r),
        .r_next (r_next_s),
        .q_bit  (q_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state and control strobes; a zero divisor waits one cycle in IDLE
    // (pend_r) and then jumps straight to DONE without raising busy.
    always_comb begin
        state_n      = state_r;
        accept_s     = 1'b0;
        run_finish_s = 1'b0;
        dz_finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_r) begin
                    dz_finish_s = 1'b1;
                    state_n     = DONE;
                end else if (bus.start) begin
                    accept_s = 1'b1;
                    state_n  = div_zero_s ? IDLE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_ITER) begin
                    run_finish_s = 1'b1;
                    state_n      = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_n  = div_zero_s ? IDLE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Working registers, status flags and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r         <= {DIVIDEND_W{1'b0}};
            d_r         <= {DIVISOR_W{1'b0}};
            r_r         <= {DIVISOR_W{1'b0}};
            cnt_r       <= {COUNT_W{1'b0}};
            pend_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
        end else begin
            busy_r <= (state_n == RUN);
            done_r <= (state_n == DONE);
            pend_r <= accept_s & div_zero_s;
            if (accept_s) begin
                q_r   <= bus.dividend;
                d_r   <= bus.divisor;
                r_r   <= {DIVISOR_W{1'b0}};
                cnt_r <= {COUNT_W{1'b0}};
                dbz_r <= 1'b0;
            end else if (state_r == RUN) begin
                q_r   <= {q_r[DIVIDEND_W-2:0], q_bit_s};
                r_r   <= r_next_s;
                cnt_r <= cnt_r + 3'd1;
            end
            if (run_finish_s) begin
                quotient_r  <= {q_r[DIVIDEND_W-2:0], q_bit_s};
                remainder_r <= r_next_s;
            end else if (dz_finish_s) begin
                quotient_r  <= DIV0_QUOTIENT;
                remainder_r <= q_r[DIVISOR_W-1:0];
                dbz_r       <= 1'b1;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule
